// File: rtl/sbit_packer_pkg.sv
// Shared types and helpers for the serial-bit to word packer.
package sbit_packer_pkg;

  typedef enum logic {S_COLLECT, S_HOLD} packer_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sbit_word_packer.sv
// Pops bits from a 1-bit FIFO, packs them LSB-first into WIDTH-bit words and
// presents each word in a single-entry output slot; FLUSH emits a partial word.
//
//   state     | meaning
//   S_COLLECT | popping bits into ACC; BIT_RD high
//   S_HOLD    | ACC holds a full or flushed word, waiting for the output slot
module sbit_word_packer
  import sbit_packer_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNTW  = cnt_width(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BIT_VALID,
  input  logic             BIT_D,
  output logic             BIT_RD,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] WORD_Q,
  output logic [CNTW-1:0]  WORD_CNT,
  output logic             WORD_VALID,
  input  logic             WORD_RD,
  output logic             BUSY
);

  packer_state_t    state, state_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] word_q_nxt;
  logic [CNTW-1:0]  word_cnt_nxt;
  logic             word_valid_nxt;
  logic             consume;
  logic             slot_free;

  assign BIT_RD    = (state == S_COLLECT);
  assign consume   = BIT_RD & BIT_VALID;
  assign slot_free = ~WORD_VALID | WORD_RD;
  assign BUSY      = (state == S_HOLD) | (cnt != '0) | WORD_VALID;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    acc_nxt        = acc;
    word_q_nxt     = WORD_Q;
    word_cnt_nxt   = WORD_CNT;
    word_valid_nxt = WORD_VALID & ~WORD_RD;
    case (state)
      S_COLLECT: begin
        if (consume) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CNTW'(i)) acc_nxt[i] = BIT_D;
          end
          cnt_nxt = cnt + CNTW'(1);
        end
        // A flush counts the bit consumed on the same cycle.
        if (consume && (cnt == CNTW'(WIDTH - 1))) begin
          state_nxt = S_HOLD;
        end else if (FLUSH && (consume || (cnt != '0))) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (slot_free) begin
          word_q_nxt     = acc;
          word_cnt_nxt   = cnt;
          word_valid_nxt = 1'b1;
          acc_nxt        = '0;
          cnt_nxt        = '0;
          state_nxt      = S_COLLECT;
        end
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_COLLECT;
      cnt        <= '0;
      acc        <= '0;
      WORD_Q     <= '0;
      WORD_CNT   <= '0;
      WORD_VALID <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      WORD_Q     <= word_q_nxt;
      WORD_CNT   <= word_cnt_nxt;
      WORD_VALID <= word_valid_nxt;
    end
  end

endmodule

// File: tb/tb_sbit_word_packer.sv
// Self-checking bench for sbit_word_packer (WIDTH=8): cycle vector table,
// back-pressure and async-reset sequences, and a random run against a bit-queue model.
module tb_sbit_word_packer;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          BIT_VALID = 1'b0;
  logic          BIT_D = 1'b0;
  logic          FLUSH = 1'b0;
  logic          WORD_RD = 1'b0;
  logic          BIT_RD;
  logic          WORD_VALID;
  logic          BUSY;
  logic [W-1:0]  WORD_Q;
  logic [CW-1:0] WORD_CNT;

  sbit_word_packer #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .BIT_VALID(BIT_VALID), .BIT_D(BIT_D), .BIT_RD(BIT_RD),
    .FLUSH(FLUSH), .WORD_Q(WORD_Q), .WORD_CNT(WORD_CNT), .WORD_VALID(WORD_VALID),
    .WORD_RD(WORD_RD), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle table: inputs held for one clock, outputs checked just after that edge.
  typedef struct {
    logic bv, bd, fl, rd;
    logic e_bitrd, e_wv, e_busy;
    logic [W-1:0] e_q;
    logic [CW-1:0] e_cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic bv, bd, fl, rd, e_bitrd, e_wv, e_busy,
                     input logic [W-1:0] q, input logic [CW-1:0] c);
    vec_t v;
    v.bv = bv; v.bd = bd; v.fl = fl; v.rd = rd;
    v.e_bitrd = e_bitrd; v.e_wv = e_wv; v.e_busy = e_busy; v.e_q = q; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  // Reference model: FIFO contents, bits gathered so far, and expected words.
  typedef struct {
    logic [W-1:0] q;
    logic [CW-1:0] c;
  } word_t;
  bit    fifo[$];
  bit    pending[$];
  word_t expw[$];
  int    taken, consumed, bits_in, bits_out;

  task automatic close_word();
    word_t w;
    w.q = '0;
    foreach (pending[i]) w.q[i] = pending[i];
    w.c = CW'(pending.size());
    expw.push_back(w);
    pending.delete();
  endtask

  task automatic tick();
    logic cons;
    word_t e;
    BIT_VALID = (fifo.size() > 0);
    BIT_D     = (fifo.size() > 0) ? fifo[0] : 1'b0;
    cons      = BIT_RD & BIT_VALID;
    if (WORD_VALID && WORD_RD) begin
      if (expw.size() == 0) begin
        check("unexpected_word", 32'(WORD_VALID), 32'd0);
      end else begin
        e = expw.pop_front();
        check("model_word_q", 32'(WORD_Q), 32'(e.q));
        check("model_word_cnt", 32'(WORD_CNT), 32'(e.c));
      end
      taken++;
      bits_out += int'(WORD_CNT);
    end
    if (cons) pending.push_back(BIT_D);
    if (pending.size() == W || (FLUSH && BIT_RD && pending.size() > 0)) close_word();
    @(posedge CLK);
    #1;
    if (cons) begin
      void'(fifo.pop_front());
      consumed++;
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      fifo.push_back(w[i]);
      bits_in++;
    end
  endtask

  initial begin
    logic [W-1:0] p;

    #1;
    check("rst_word_valid", 32'(WORD_VALID), 32'd0);
    check("rst_word_q", 32'(WORD_Q), 32'd0);
    check("rst_word_cnt", 32'(WORD_CNT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("post_rst_bit_rd", 32'(BIT_RD), 32'd1);

    // Full word 0x4D, then flushed partial 0x03, clean word 0x96, empty flush, same-cycle flush.
    p = 8'h4D;
    for (int i = 0; i < W; i++) add(1, p[i], 0, 1, (i == W - 1) ? 1'b0 : 1'b1, 0, 1, 8'h00, 0);
    add(0, 0, 0, 1, 1, 1, 1, 8'h4D, 8);
    add(0, 0, 0, 1, 1, 0, 0, 8'h4D, 8);
    add(1, 1, 0, 1, 1, 0, 1, 8'h4D, 8);
    add(1, 1, 0, 1, 1, 0, 1, 8'h4D, 8);
    add(1, 0, 0, 1, 1, 0, 1, 8'h4D, 8);
    add(0, 0, 1, 1, 0, 0, 1, 8'h4D, 8);
    add(0, 0, 0, 0, 1, 1, 1, 8'h03, 3);
    add(0, 0, 0, 0, 1, 1, 1, 8'h03, 3);
    add(0, 0, 0, 1, 1, 0, 0, 8'h03, 3);
    p = 8'h96;
    for (int i = 0; i < W; i++) add(1, p[i], 0, 1, (i == W - 1) ? 1'b0 : 1'b1, 0, 1, 8'h03, 3);
    add(0, 0, 0, 1, 1, 1, 1, 8'h96, 8);
    add(0, 0, 0, 1, 1, 0, 0, 8'h96, 8);
    add(0, 0, 1, 1, 1, 0, 0, 8'h96, 8);
    add(1, 1, 1, 1, 0, 0, 1, 8'h96, 8);
    add(0, 0, 0, 1, 1, 1, 1, 8'h01, 1);
    add(0, 0, 0, 1, 1, 0, 0, 8'h01, 1);

    foreach (vecs[k]) begin
      BIT_VALID = vecs[k].bv;
      BIT_D     = vecs[k].bd;
      FLUSH     = vecs[k].fl;
      WORD_RD   = vecs[k].rd;
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d_bit_rd", k), 32'(BIT_RD), 32'(vecs[k].e_bitrd));
      check($sformatf("vec%0d_word_valid", k), 32'(WORD_VALID), 32'(vecs[k].e_wv));
      check($sformatf("vec%0d_busy", k), 32'(BUSY), 32'(vecs[k].e_busy));
      check($sformatf("vec%0d_word_q", k), 32'(WORD_Q), 32'(vecs[k].e_q));
      check($sformatf("vec%0d_word_cnt", k), 32'(WORD_CNT), 32'(vecs[k].e_cnt));
    end

    // Back-pressure: slot and ACC fill, popping stops after 16 bits, then drain in order.
    FLUSH = 1'b0;
    WORD_RD = 1'b0;
    consumed = 0;
    taken = 0;
    push_word(8'hA5);
    push_word(8'h3C);
    push_word(8'h81);
    for (int c = 0; c < 40; c++) tick();
    check("bp_consumed", 32'(consumed), 32'd16);
    check("bp_bit_rd", 32'(BIT_RD), 32'd0);
    check("bp_word_valid", 32'(WORD_VALID), 32'd1);
    WORD_RD = 1'b1;
    for (int c = 0; c < 100 && taken < 3; c++) tick();
    check("bp_words_taken", 32'(taken), 32'd3);
    check("bp_fifo_empty", 32'(fifo.size()), 32'd0);

    // Async reset mid-word with a full slot, then a clean 0xFF word.
    WORD_RD = 1'b0;
    push_word(8'h5A);
    for (int i = 0; i < 5; i++) fifo.push_back(1'b1);
    for (int c = 0; c < 15; c++) tick();
    check("pre_rst_word_valid", 32'(WORD_VALID), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_word_valid", 32'(WORD_VALID), 32'd0);
    check("async_rst_word_q", 32'(WORD_Q), 32'd0);
    check("async_rst_word_cnt", 32'(WORD_CNT), 32'd0);
    check("async_rst_busy", 32'(BUSY), 32'd0);
    fifo.delete();
    pending.delete();
    expw.delete();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    taken = 0;
    WORD_RD = 1'b1;
    push_word(8'hFF);
    for (int c = 0; c < 30 && taken < 1; c++) tick();
    check("post_rst_ff_taken", 32'(taken), 32'd1);

    // Random FIFO writes, reads and flushes against the model.
    bits_in = 0;
    bits_out = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 1 && fifo.size() < 16) begin
        fifo.push_back(1'($urandom_range(0, 1)));
        bits_in++;
      end
      WORD_RD = ($urandom_range(0, 3) != 0);
      FLUSH   = ($urandom_range(0, 15) == 0);
      tick();
    end
    WORD_RD = 1'b1;
    FLUSH   = 1'b1;
    for (int c = 0; c < 200; c++) tick();
    FLUSH = 1'b0;
    tick();
    check("rand_fifo_drained", 32'(fifo.size()), 32'd0);
    check("rand_model_empty", 32'(expw.size() + pending.size()), 32'd0);
    check("rand_bits_conserved", 32'(bits_out), 32'(bits_in));
    check("rand_final_word_valid", 32'(WORD_VALID), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
